// File: rtl/construct_data.sv
// Packs a stream of OSIZE-bit pixels MSB-first into ISIZE-bit words; pixels may straddle words.
// One-cycle latency from the completing accept to ovalid; iready drops while the output word is held or a flush is pending.
module construct_data #(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24,
  parameter int FW    = $clog2(ISIZE + OSIZE) + 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 ialign,
  input  logic                 iflush,
  input  logic                 ivalid,
  output logic                 iready,
  input  logic [OSIZE-1:0]     idata,
  input  logic                 ilast,
  output logic [ISIZE-1:0]     odata,
  output logic                 ovalid,
  input  logic                 oready,
  output logic                 olast,
  output logic [ISIZE/8-1:0]   omask
);

  localparam int AW = ISIZE + OSIZE;
  localparam int NB = ISIZE / 8;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [ISIZE-1:0]   odata_q, odata_d;
  logic               ovalid_q, ovalid_d;
  logic               olast_q, olast_d;
  logic [NB-1:0]      omask_q, omask_d;

  logic               out_free;
  logic               accept;
  logic [AW-1:0]      acc_new;
  logic [FW-1:0]      fill_new;
  logic [FW-1:0]      residual;
  logic [FW-1:0]      fill_after;
  logic               complete;
  logic [ISIZE-1:0]   word_sel;
  logic [ISIZE-1:0]   flush_word;
  logic [FW-1:0]      nbytes;
  logic [NB-1:0]      flush_mask;

  assign out_free = ~ovalid_q | oready;
  assign iready   = (state_q == RUN) & out_free & ~ialign;
  assign accept   = ivalid & iready;

  assign acc_new  = AW'({acc_q, idata});
  assign fill_new = fill_q + FW'(OSIZE);
  assign complete = fill_new >= FW'(ISIZE);
  assign residual = fill_new - FW'(ISIZE);
  assign word_sel = ISIZE'(acc_new >> residual);

  // Valid bits sit in acc_q[fill-1:0]; appending ISIZE zeros and shifting by fill left-aligns them.
  assign flush_word = ISIZE'({acc_q, {ISIZE{1'b0}}} >> fill_q);
  assign nbytes     = (fill_q + FW'(7)) >> 3;
  assign flush_mask = ~({NB{1'b1}} >> nbytes);

  always_comb begin
    fill_after = fill_q;
    if (accept) fill_after = complete ? residual : fill_new;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    fill_d   = fill_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q & ~oready;
    olast_d  = olast_q;
    omask_d  = omask_q;
    if (ialign) begin
      state_d  = RUN;
      acc_d    = '0;
      fill_d   = '0;
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
      omask_d  = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            acc_d  = acc_new;
            fill_d = fill_after;
            if (complete) begin
              odata_d  = word_sel;
              ovalid_d = 1'b1;
              omask_d  = '1;
              olast_d  = ilast & (residual == '0);
            end
          end
          // A residual left at frame end (ilast or iflush) goes out as a padded last word.
          if (((accept & ilast) | iflush) && (fill_after != '0)) state_d = FLUSH;
        end
        FLUSH: begin
          if (out_free) begin
            odata_d  = flush_word;
            ovalid_d = 1'b1;
            olast_d  = 1'b1;
            omask_d  = flush_mask;
            fill_d   = '0;
            acc_d    = '0;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      acc_q    <= '0;
      fill_q   <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      omask_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      omask_q  <= omask_d;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign olast  = olast_q;
  assign omask  = omask_q;

endmodule

// File: tb/tb_construct_data.sv
// Bench for construct_data: directed scenarios plus random traffic against a bit-queue packing model.
module tb_construct_data;

  localparam int IS = 256;
  localparam int OS = 24;
  localparam int NB = IS / 8;

  typedef struct {
    logic [IS-1:0] d;
    logic          l;
    logic [NB-1:0] m;
  } word_t;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic            ialign = 1'b0, iflush = 1'b0, ivalid = 1'b0, ilast = 1'b0, oready = 1'b1;
  logic [OS-1:0]   idata = '0;
  logic            iready, ovalid, olast;
  logic [IS-1:0]   odata;
  logic [NB-1:0]   omask;

  logic            v32 = 1'b0, l32 = 1'b0, r32, ov32, ol32;
  logic [31:0]     d32 = '0;
  logic [IS-1:0]   od32;
  logic [NB-1:0]   om32;

  int n_cmp = 0;
  int n_bad = 0;

  bit    bits_q[$];
  word_t exp_q[$];
  word_t got_q[$];
  logic          hold = 1'b0;
  logic [IS-1:0] hold_dat;

  always #5 clock = ~clock;

  construct_data #(.ISIZE(IS), .OSIZE(OS)) dut (
    .clock(clock), .rst_n(rst_n), .ialign(ialign), .iflush(iflush),
    .ivalid(ivalid), .iready(iready), .idata(idata), .ilast(ilast),
    .odata(odata), .ovalid(ovalid), .oready(oready), .olast(olast), .omask(omask)
  );

  construct_data #(.ISIZE(IS), .OSIZE(32)) dut32 (
    .clock(clock), .rst_n(rst_n), .ialign(1'b0), .iflush(1'b0),
    .ivalid(v32), .iready(r32), .idata(d32), .ilast(l32),
    .odata(od32), .ovalid(ov32), .oready(1'b1), .olast(ol32), .omask(om32)
  );

  task automatic chk(input string tag, input logic [IS-1:0] obs, input logic [IS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a flat bit stream; every 256 bits is a word, leftovers at frame end are left-aligned.
  task automatic emit_partial();
    word_t w;
    int n;
    n = bits_q.size();
    w.d = '0;
    w.m = '0;
    w.l = 1'b1;
    for (int k = 0; k < n; k++) w.d[IS-1-k] = bits_q[k];
    for (int b = 0; b < (n + 7) / 8; b++) w.m[NB-1-b] = 1'b1;
    bits_q.delete();
    exp_q.push_back(w);
  endtask

  always @(negedge clock) begin
    word_t e;
    word_t w;
    logic  acc;
    if (!rst_n) begin
      bits_q.delete();
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_vld", ovalid, 1);
        chk("hold_dat", odata, hold_dat);
      end
      hold     = ovalid && !oready && !ialign;
      hold_dat = odata;
      if (ovalid && oready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word_data", odata, e.d);
          chk("word_last", olast, e.l);
          chk("word_mask", omask, e.m);
          w.d = odata; w.l = olast; w.m = omask;
          got_q.push_back(w);
        end
      end
      acc = ivalid && iready;
      if (acc) begin
        for (int i = OS - 1; i >= 0; i--) bits_q.push_back(idata[i]);
        if (bits_q.size() >= IS) begin
          for (int k = 0; k < IS; k++) w.d[IS-1-k] = bits_q.pop_front();
          w.m = '1;
          w.l = ilast && (bits_q.size() == 0);
          exp_q.push_back(w);
        end
      end
      if (((acc && ilast) || iflush) && bits_q.size() > 0) emit_partial();
      if (ialign) begin
        bits_q.delete();
        exp_q.delete();
      end
    end
  end

  task automatic push(input logic [OS-1:0] d, input logic l);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    ivalid = 1'b1; idata = d; ilast = l;
    while (!ok && n < 200) begin
      @(negedge clock);
      ok = iready;
      @(posedge clock); #1;
      n++;
    end
    ivalid = 1'b0; ilast = 1'b0;
    chk("push_accept", ok, 1);
  endtask

  task automatic frame(input int n, input int last_idx);
    for (int i = 0; i < n; i++) push(OS'(i + 1), i == last_idx);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    @(posedge clock); #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_flush();
    iflush = 1'b1;
    @(posedge clock); #1;
    iflush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [263:0]  t;
    logic [IS-1:0] w0, e;
    logic [IS-1:0] w32;

    t = '0;
    for (int i = 0; i < 11; i++) t = {t[239:0], 24'(i + 1)};
    w0 = t[263:8];

    repeat (3) @(posedge clock);
    #1;
    chk("rst_odata", odata, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_olast", olast, 0);
    chk("rst_omask", omask, 0);
    rst_n = 1'b1;
    @(negedge clock);
    chk("rst_iready", iready, 1);
    @(posedge clock); #1;

    // Integer ratio 256/32: one full last word, never a flush cycle.
    w32 = '0;
    for (int i = 0; i < 8; i++) begin
      v32 = 1'b1; d32 = 32'(i + 1); l32 = (i == 7);
      w32 = {w32[IS-33:0], 32'(i + 1)};
      @(negedge clock);
      chk("r32_iready", r32, 1);
      @(posedge clock); #1;
    end
    v32 = 1'b0; l32 = 1'b0;
    @(negedge clock);
    chk("r32_ovalid", ov32, 1);
    chk("r32_odata", od32, w32);
    chk("r32_olast", ol32, 1);
    chk("r32_omask", om32, {NB{1'b1}});
    chk("r32_noflush", r32, 1);
    @(posedge clock); #1;

    // 32 pixels, ilast on the last: three full words.
    got_q.delete();
    frame(32, 31);
    drain();
    chk("s1_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("s1_w0", got_q[0].d, w0);
      chk("s1_w0_last", got_q[0].l, 0);
      chk("s1_w2_low", got_q[2].d[23:0], 24'h000020);
      chk("s1_w2_last", got_q[2].l, 1);
      chk("s1_w2_mask", got_q[2].m, 32'hFFFFFFFF);
    end

    // 11 pixels, ilast on p10: full word then one-byte flush word.
    got_q.delete();
    frame(11, 10);
    @(negedge clock);
    chk("s2_flush_iready", iready, 0);
    @(negedge clock);
    chk("s2_run_iready", iready, 1);
    drain();
    chk("s2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      e = {8'h0B, 248'h0};
      chk("s2_w0", got_q[0].d, w0);
      chk("s2_w1", got_q[1].d, e);
      chk("s2_w1_mask", got_q[1].m, 32'h80000000);
      chk("s2_w1_last", got_q[1].l, 1);
    end

    // iflush after 3 pixels, then iflush with nothing buffered.
    got_q.delete();
    frame(3, -1);
    pulse_flush();
    drain();
    chk("s4_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      e = {24'h000001, 24'h000002, 24'h000003, 184'h0};
      chk("s4_data", got_q[0].d, e);
      chk("s4_mask", got_q[0].m, 32'hFF800000);
      chk("s4_last", got_q[0].l, 1);
    end
    pulse_flush();
    repeat (4) begin
      @(negedge clock);
      chk("s4_empty_flush", ovalid, 0);
    end
    @(posedge clock); #1;

    // Backpressure for 20 cycles while pixels keep coming.
    oready = 1'b0;
    fork
      frame(15, 14);
      begin
        repeat (20) @(posedge clock);
        #1;
        chk("bp_iready", iready, 0);
        chk("bp_ovalid", ovalid, 1);
        oready = 1'b1;
      end
    join
    drain();

    // ialign with a held word and fill=16, then a fresh frame.
    frame(21, -1);
    oready = 1'b0;
    push(24'h000016, 1'b0);
    ialign = 1'b1;
    @(negedge clock);
    chk("al_iready", iready, 0);
    @(posedge clock); #1;
    ialign = 1'b0;
    chk("al_ovalid", ovalid, 0);
    oready = 1'b1;
    got_q.delete();
    frame(11, 10);
    drain();
    chk("al_count", got_q.size(), 2);
    if (got_q.size() == 2) chk("al_w0", got_q[0].d, w0);

    // Async reset with a word held.
    oready = 1'b0;
    frame(11, -1);
    @(posedge clock); #3;
    rst_n = 1'b0;
    #1;
    chk("ar_odata", odata, 0);
    chk("ar_ovalid", ovalid, 0);
    chk("ar_omask", omask, 0);
    chk("ar_olast", olast, 0);
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    oready = 1'b1;
    got_q.delete();
    frame(11, 10);
    drain();
    chk("ar_count", got_q.size(), 2);
    if (got_q.size() == 2) chk("ar_w0", got_q[0].d, w0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      ivalid = ($urandom_range(0, 3) != 0);
      idata  = OS'($urandom);
      ilast  = ($urandom_range(0, 15) == 0);
      oready = ($urandom_range(0, 3) != 0);
      iflush = ($urandom_range(0, 31) == 0);
      ialign = ($urandom_range(0, 199) == 0);
      @(posedge clock); #1;
    end
    ivalid = 1'b0; ilast = 1'b0; ialign = 1'b0; oready = 1'b1;
    iflush = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    pulse_flush();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
